cp0_int_ctrl: RTL
=================

Name: cp0_int_ctrl

Overview:
Interrupt responder (CP0 subset) for the pipelined MIPS core. It accepts the `IntReq` lines raised by interrupt sources, masks and prioritises them against the status register, and signals the pipeline to take the interrupt at the MEM stage. It saves the return PC in EPC and releases exception level on ERET. It also provides MFC0/MTC0 access to SR, Cause, EPC and PRId.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, PC loaded by the pipeline when IntTaken=1.
- PRID_VAL, 32'h0000_0001, constant read from register 15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- IntReq  in  6  hardware interrupt requests; level-sensitive, bit i maps to IP[i].
- PCM  in  32  PC of the instruction currently in MEM.
- BDM  in  1  MEM instruction is in a branch delay slot.
- ValidM  in  1  MEM holds a real instruction (not a bubble).
- We  in  1  MTC0 write enable (MEM stage).
- A  in  5  CP0 register number for read/write.
- DIn  in  32  MTC0 write data.
- EXLClr  in  1  ERET in MEM; clears EXL.
- IntTaken  out  1  take interrupt this cycle; flush pipeline, load IntPC.
- IntPC  out  32  constant HANDLER_ADDR.
- EPCOut  out  32  current EPC, feeds ERET PC mux.
- DOut  out  32  MFC0 read data, combinational on A.

Behaviour:
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): BD[31], IP[15:10]; all other bits read 0; read-only to software.
  - EPC (14): 32 bits, bits [1:0] forced 0.
  - PRId (15): PRID_VAL, read-only.
- Reset (async, immediate): SR=0, Cause=0, EPC=0. Resulting outputs: IntTaken=0, EPCOut=0, DOut=0 for every A except 15.
- IP pipeline: IP <= IntReq every rising edge, one-cycle latency. IP tracks the level; it is never sticky.
- IntTaken is combinational: IE & ~EXL & ValidM & |(IP & IM).
  - Bubble in MEM (ValidM=0): interrupt deferred to the next valid instruction.
- On an edge with IntTaken=1:
  - EXL <= 1.
  - BD <= BDM.
  - EPC <= BDM ? {PCM[31:2],2'b00} - 4 : {PCM[31:2],2'b00}.
  - Any concurrent MTC0 write is discarded, since that instruction is being flushed.
- EXLClr=1 (IntTaken necessarily 0 because EXL=1): EXL <= 0 at the edge.
  - Pending masked interrupts may be taken from the next cycle onward.
- MTC0 (We=1, IntTaken=0):
  - A=12 writes IM, EXL, IE from DIn. If EXLClr is also 1, EXL is forced 0; other fields take DIn.
  - A=14 writes EPC, low bits dropped.
  - A=13, A=15 and unmapped A: write ignored.
- MFC0: DOut = register selected by A. Unmapped A reads 0. Same-cycle write is not bypassed; DOut shows the pre-edge value.
- EPC arithmetic wraps modulo 2^32: PCM=0, BDM=1 gives EPC=32'hFFFF_FFFC.
- No nesting: while EXL=1, IntTaken stays 0 regardless of IP, IM and IE.

Test Plan:
1. Reset mid-run with SR=32'h0000_FC01 and EPC set -> SR, Cause and EPC read 0 immediately; IntTaken=0.
2. MTC0 SR=32'h0000_0401, IntReq=6'b000001, PCM=32'h0000_3010, BDM=0, ValidM=1 -> IntTaken=1 the cycle after IntReq rises. Next cycle: EPC=32'h0000_3010, SR=32'h0000_0403, Cause=32'h0000_0400.
3. Same as 2 but BDM=1, PCM=32'h0000_3014 -> EPC=32'h0000_3010, Cause[31]=1.
4. IntReq=6'b000010 with IM=6'b000001 -> IntTaken stays 0 and Cause IP reads 6'b000010. Then MTC0 IM=6'b000011 -> IntTaken=1.
5. EXL=1 with an unmasked request held -> IntTaken=0. Pulse EXLClr -> IntTaken=1 in the following cycle. ValidM=0 that cycle -> IntTaken=0 until ValidM=1.
6. IntTaken and We (A=14, DIn=32'h1234_5678) in the same cycle -> EPC = interrupted PC, not 32'h1234_5678. MTC0 A=13 -> Cause unchanged.

Source files
------------

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt responder: SR/Cause/EPC/PRId, masked level interrupts taken at MEM,
// EPC capture on entry and EXL release on ERET.
module cp0_int_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL     = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  IntReq,
  input  logic [31:0] PCM,
  input  logic        BDM,
  input  logic        ValidM,
  input  logic        We,
  input  logic [4:0]  A,
  input  logic [31:0] DIn,
  input  logic        EXLClr,
  output logic        IntTaken,
  output logic [31:0] IntPC,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NIRQ = 6;
  localparam int unsigned AW   = 5;
  localparam int unsigned EW   = XLEN - 2;

  localparam logic [AW-1:0] A_SR    = AW'(12);
  localparam logic [AW-1:0] A_CAUSE = AW'(13);
  localparam logic [AW-1:0] A_EPC   = AW'(14);
  localparam logic [AW-1:0] A_PRID  = AW'(15);

  logic [NIRQ-1:0] im_q, im_d;
  logic [NIRQ-1:0] ip_q, ip_d;
  logic            exl_q, exl_d;
  logic            ie_q, ie_d;
  logic            bd_q, bd_d;
  logic [EW-1:0]   epc_q, epc_d;

  logic [EW-1:0]   epc_take;
  logic [XLEN-1:0] sr_rd, cause_rd, epc_rd;
  logic            unused_pcm;

  assign unused_pcm = ^PCM[1:0];

  // EPC stores only the word address; a delay-slot victim restarts at its branch.
  assign epc_take = BDM ? (PCM[XLEN-1:2] - EW'(1)) : PCM[XLEN-1:2];

  assign IntTaken = ie_q & ~exl_q & ValidM & (|(ip_q & im_q));
  assign IntPC    = HANDLER_ADDR;

  assign sr_rd    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_rd = {bd_q, 15'b0, ip_q, 10'b0};
  assign epc_rd   = {epc_q, 2'b00};
  assign EPCOut   = epc_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q  <= '0;
      ip_q  <= '0;
      exl_q <= 1'b0;
      ie_q  <= 1'b0;
      bd_q  <= 1'b0;
      epc_q <= '0;
    end else begin
      im_q  <= im_d;
      ip_q  <= ip_d;
      exl_q <= exl_d;
      ie_q  <= ie_d;
      bd_q  <= bd_d;
      epc_q <= epc_d;
    end
  end

  // Interrupt entry wins over MTC0/ERET: the MEM instruction is being flushed.
  always_comb begin
    im_d  = im_q;
    ip_d  = IntReq;
    exl_d = exl_q;
    ie_d  = ie_q;
    bd_d  = bd_q;
    epc_d = epc_q;
    if (IntTaken) begin
      exl_d = 1'b1;
      bd_d  = BDM;
      epc_d = epc_take;
    end else begin
      if (We && (A == A_SR)) begin
        im_d  = DIn[15:10];
        exl_d = DIn[1];
        ie_d  = DIn[0];
      end
      if (We && (A == A_EPC)) begin
        epc_d = DIn[XLEN-1:2];
      end
      if (EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  // MFC0 read mux shows pre-edge state; no write bypass.
  always_comb begin
    DOut = '0;
    case (A)
      A_SR:    DOut = sr_rd;
      A_CAUSE: DOut = cause_rd;
      A_EPC:   DOut = epc_rd;
      A_PRID:  DOut = PRID_VAL;
      default: DOut = '0;
    endcase
  end

endmodule
